// File: rtl/sprite_pkg.sv
// Shared types and geometry for the sprite fetch path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sprite_pkg;

  localparam int TILE_COLS    = 30;  // playfield tiles per row (240 px)
  localparam int TILE_ROWS    = 32;  // playfield tile rows (256 px)
  localparam int NUM_MO       = 16;  // motion RAM slots
  localparam int MAX_PER_LINE = 8;   // motion objects kept per scanline
  localparam int MO_W         = 16;  // motion object width in pixels
  localparam int MO_H         = 8;   // motion object height in pixels

  // Motion RAM word layout: {spriteID, x, y}
  typedef struct packed {
    logic [7:0] id;
    logic [7:0] x;
    logic [7:0] y;
  } mo_entry_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_t;

endpackage

// File: rtl/mo_line_buffer.sv
// Scans motion RAM for the upcoming line and answers per-pixel motion-object hit queries.
// Latency: scan occupies NUM_MO+1 cycles after line_start; the pixel query is combinational.
// Backpressure: none; the scan free-runs and a new line_start restarts it from slot 0.
module mo_line_buffer
  import sprite_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       line_start,
  input  logic [7:0] line_next,
  output logic [3:0] mo_addr,
  input  mo_entry_t  mo_data,
  input  logic [7:0] qry_row,
  input  logic [7:0] qry_col,
  output logic       hit,
  output logic [7:0] entry_id,
  output logic [3:0] dx,
  output logic [2:0] dy,
  output logic       overflow
);

  localparam int CW = $clog2(NUM_MO + 1);        // scan counter 0..NUM_MO
  localparam int AW = $clog2(NUM_MO);            // motion RAM address width
  localparam int NW = $clog2(MAX_PER_LINE + 1);  // buffer fill count 0..MAX_PER_LINE
  localparam int IW = $clog2(MAX_PER_LINE);      // buffer index width

  scan_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    line_q, line_d;
  logic [NW-1:0] num_q, num_d;
  logic          ovf_q, ovf_d;
  mo_entry_t     ent_q [MAX_PER_LINE];
  mo_entry_t     ent_d [MAX_PER_LINE];
  logic [7:0]    row_off;
  logic [7:0]    col_off [MAX_PER_LINE];

  // cnt_q doubles as the read address; data for slot cnt_q-1 is on mo_data this cycle
  assign mo_addr  = cnt_q[AW-1:0];
  assign overflow = ovf_q;

  // Scan FSM next state: append hits in slot order, drop and flag when the buffer is full
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    line_d  = line_q;
    num_d   = num_q;
    ovf_d   = ovf_q;
    ent_d   = ent_q;
    row_off = line_q - mo_data.y;
    if (line_start) begin
      state_d = SCAN;
      cnt_d   = '0;
      line_d  = line_next;
      num_d   = '0;
    end else if (state_q == SCAN) begin
      if (cnt_q != '0 && row_off < 8'(MO_H)) begin
        if (num_q < NW'(MAX_PER_LINE)) begin
          ent_d[num_q[IW-1:0]] = mo_data;
          num_d = num_q + 1'b1;
        end else begin
          ovf_d = 1'b1;
        end
      end
      if (cnt_q == CW'(NUM_MO)) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Scan state and line buffer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      line_q  <= '0;
      num_q   <= '0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < MAX_PER_LINE; i++) ent_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      line_q  <= line_d;
      num_q   <= num_d;
      ovf_q   <= ovf_d;
      ent_q   <= ent_d;
    end
  end

  // Column offset of the queried pixel against every buffered object (8-bit wrap)
  always_comb begin
    for (int i = 0; i < MAX_PER_LINE; i++) col_off[i] = qry_col - ent_q[i].x;
  end

  // Priority match: walk high to low so the lowest slot index overrides; buffer is dark while scanning
  always_comb begin
    hit      = 1'b0;
    entry_id = '0;
    dx       = '0;
    dy       = '0;
    for (int i = MAX_PER_LINE - 1; i >= 0; i--) begin
      if (state_q == IDLE && NW'(i) < num_q && col_off[i] < 8'(MO_W)) begin
        hit      = 1'b1;
        entry_id = ent_q[i].id;
        dx       = col_off[i][3:0];
        dy       = 3'(qry_row - ent_q[i].y);
      end
    end
  end

endmodule

// File: rtl/sprite_fetch_sequencer.sv
// Raster-order sprite fetch: VRAM address, motion-object override, lookup request, colour realign.
// Latency: fixed 4 cycles from pixRow/pixCol to outColor/outValid.
// Backpressure: none; the pixel stream is paced by the VGA timing generator.
module sprite_fetch_sequencer
  import sprite_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  pixRow,
  input  logic [7:0]  pixCol,
  input  logic        pixValid,
  input  logic        lineStart,
  input  logic [7:0]  lineNext,
  output logic [9:0]  vramAddr,
  input  logic [7:0]  vramData,
  output logic [3:0]  moAddr,
  input  logic [23:0] moData,
  output logic [7:0]  lkSpriteID,
  output logic [2:0]  lkTileRow,
  output logic [2:0]  lkTileCol,
  output logic        lkMotionSelect,
  output logic        lkMotionWide,
  input  logic [1:0]  lkColorCode,
  output logic [1:0]  outColor,
  output logic        outValid,
  output logic        outIsMotion,
  output logic        moOverflow
);

  mo_entry_t  mo_in;
  logic       mo_hit;
  logic [7:0] mo_id;
  logic [3:0] mo_dx;
  logic [2:0] mo_dy;

  logic [7:0] s1_row_q, s1_row_d, s1_col_q, s1_col_d;
  logic       s1_vld_q, s1_vld_d;
  logic       s2_vld_q, s2_vld_d, s2_mo_q, s2_mo_d;
  logic       s3_vld_q, s3_vld_d, s3_mo_q, s3_mo_d;
  logic [7:0] lk_id_q, lk_id_d;
  logic [2:0] lk_row_q, lk_row_d, lk_col_q, lk_col_d;
  logic       lk_sel_q, lk_sel_d, lk_wide_q, lk_wide_d;
  logic [1:0] out_color_q, out_color_d;
  logic       out_vld_q, out_vld_d, out_mo_q, out_mo_d;

  assign mo_in    = moData;
  assign vramAddr = 10'(pixRow[7:3]) * 10'(TILE_COLS) + 10'(pixCol[7:3]);

  mo_line_buffer u_mo_line_buffer (
    .clk        (clk),
    .rst        (rst),
    .line_start (lineStart),
    .line_next  (lineNext),
    .mo_addr    (moAddr),
    .mo_data    (mo_in),
    .qry_row    (s1_row_q),
    .qry_col    (s1_col_q),
    .hit        (mo_hit),
    .entry_id   (mo_id),
    .dx         (mo_dx),
    .dy         (mo_dy),
    .overflow   (moOverflow)
  );

  // Pipeline next state: lookup request built when vramData lands, colour captured when it returns
  always_comb begin
    s1_row_d    = pixRow;
    s1_col_d    = pixCol;
    s1_vld_d    = pixValid;
    s2_vld_d    = s1_vld_q;
    s2_mo_d     = s1_vld_q & mo_hit;
    s3_vld_d    = s2_vld_q;
    s3_mo_d     = s2_mo_q;
    lk_id_d     = lk_id_q;
    lk_row_d    = lk_row_q;
    lk_col_d    = lk_col_q;
    lk_sel_d    = lk_sel_q;
    lk_wide_d   = lk_wide_q;
    out_color_d = s3_vld_q ? lkColorCode : out_color_q;
    out_vld_d   = s3_vld_q;
    out_mo_d    = s3_vld_q & s3_mo_q;
    if (s1_vld_q) begin
      if (mo_hit) begin
        lk_id_d   = mo_id;
        lk_sel_d  = 1'b1;
        lk_wide_d = mo_dx[3];
        lk_row_d  = mo_dy;
        lk_col_d  = mo_dx[2:0];
      end else begin
        lk_id_d   = vramData;
        lk_sel_d  = 1'b0;
        lk_wide_d = 1'b0;
        lk_row_d  = s1_row_q[2:0];
        lk_col_d  = s1_col_q[2:0];
      end
    end
  end

  // Pipeline, lookup request and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_row_q    <= '0;
      s1_col_q    <= '0;
      s1_vld_q    <= 1'b0;
      s2_vld_q    <= 1'b0;
      s2_mo_q     <= 1'b0;
      s3_vld_q    <= 1'b0;
      s3_mo_q     <= 1'b0;
      lk_id_q     <= '0;
      lk_row_q    <= '0;
      lk_col_q    <= '0;
      lk_sel_q    <= 1'b0;
      lk_wide_q   <= 1'b0;
      out_color_q <= '0;
      out_vld_q   <= 1'b0;
      out_mo_q    <= 1'b0;
    end else begin
      s1_row_q    <= s1_row_d;
      s1_col_q    <= s1_col_d;
      s1_vld_q    <= s1_vld_d;
      s2_vld_q    <= s2_vld_d;
      s2_mo_q     <= s2_mo_d;
      s3_vld_q    <= s3_vld_d;
      s3_mo_q     <= s3_mo_d;
      lk_id_q     <= lk_id_d;
      lk_row_q    <= lk_row_d;
      lk_col_q    <= lk_col_d;
      lk_sel_q    <= lk_sel_d;
      lk_wide_q   <= lk_wide_d;
      out_color_q <= out_color_d;
      out_vld_q   <= out_vld_d;
      out_mo_q    <= out_mo_d;
    end
  end

  assign lkSpriteID     = lk_id_q;
  assign lkTileRow      = lk_row_q;
  assign lkTileCol      = lk_col_q;
  assign lkMotionSelect = lk_sel_q;
  assign lkMotionWide   = lk_wide_q;
  assign outColor       = out_color_q;
  assign outValid       = out_vld_q;
  assign outIsMotion    = out_mo_q;

endmodule

// File: tb/tb_sprite_fetch_sequencer.sv
// Directed bench for sprite_fetch_sequencer with VRAM, motion RAM and pixel-lookup models.
// Latency: checks lk* at t+2 and out* at t+4 after each presented pixel.
// Backpressure: none exercised; the design has no stall path.
module tb_sprite_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  pixRow, pixCol, lineNext;
  logic        pixValid, lineStart;
  logic [9:0]  vramAddr;
  logic [7:0]  vramData = '0;
  logic [3:0]  moAddr;
  logic [23:0] moData = '0;
  logic [7:0]  lkSpriteID;
  logic [2:0]  lkTileRow, lkTileCol;
  logic        lkMotionSelect, lkMotionWide;
  logic [1:0]  lkColorCode = '0;
  logic [1:0]  outColor;
  logic        outValid, outIsMotion, moOverflow;

  logic [23:0] mo_mem [16];
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  sprite_fetch_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .pixRow         (pixRow),
    .pixCol         (pixCol),
    .pixValid       (pixValid),
    .lineStart      (lineStart),
    .lineNext       (lineNext),
    .vramAddr       (vramAddr),
    .vramData       (vramData),
    .moAddr         (moAddr),
    .moData         (moData),
    .lkSpriteID     (lkSpriteID),
    .lkTileRow      (lkTileRow),
    .lkTileCol      (lkTileCol),
    .lkMotionSelect (lkMotionSelect),
    .lkMotionWide   (lkMotionWide),
    .lkColorCode    (lkColorCode),
    .outColor       (outColor),
    .outValid       (outValid),
    .outIsMotion    (outIsMotion),
    .moOverflow     (moOverflow)
  );

  // Memory and lookup models: each answers one cycle after its address/request
  always @(posedge clk) begin
    vramData    <= vramAddr[7:0] ^ 8'h25;
    moData      <= mo_mem[moAddr];
    lkColorCode <= lkSpriteID[1:0];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mo();
    for (int i = 0; i < 16; i++) mo_mem[i] = {8'h00, 8'h00, 8'hF0};
  endtask

  task automatic do_scan(input logic [7:0] line);
    @(negedge clk); lineStart = 1'b1; lineNext = line;
    @(negedge clk); lineStart = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  task automatic run_pixel(input string tag, input logic [7:0] r, input logic [7:0] c,
                           input logic [7:0] e_id, input logic [2:0] e_tr, input logic [2:0] e_tc,
                           input logic e_sel, input logic e_wide);
    @(negedge clk); pixRow = r; pixCol = c; pixValid = 1'b1;
    @(negedge clk); pixValid = 1'b0;
    @(negedge clk);
    chk({tag, ".id"},   lkSpriteID,     e_id);
    chk({tag, ".trow"}, lkTileRow,      e_tr);
    chk({tag, ".tcol"}, lkTileCol,      e_tc);
    chk({tag, ".sel"},  lkMotionSelect, e_sel);
    chk({tag, ".wide"}, lkMotionWide,   e_wide);
    @(negedge clk);
    chk({tag, ".early"}, outValid, 1'b0);
    @(negedge clk);
    chk({tag, ".vld"},   outValid,    1'b1);
    chk({tag, ".color"}, outColor,    e_id[1:0]);
    chk({tag, ".ismo"},  outIsMotion, e_sel);
  endtask

  initial begin
    rst = 1'b1; pixRow = '0; pixCol = '0; pixValid = 1'b0; lineStart = 1'b0; lineNext = '0;
    clear_mo();
    repeat (3) @(negedge clk);
    chk("rst.outValid", outValid, 1'b0);
    chk("rst.outColor", outColor, 2'd0);
    chk("rst.lkId",     lkSpriteID, 8'h00);
    chk("rst.moAddr",   moAddr, 4'd0);
    chk("rst.ovf",      moOverflow, 1'b0);
    rst = 1'b0;

    // Empty motion RAM: pure playfield
    do_scan(8'd0);
    run_pixel("pf", 8'd13, 8'd20, 8'h05, 3'd5, 3'd4, 1'b0, 1'b0);

    // Single object in slot 3, including its column edges
    mo_mem[3] = {8'h14, 8'd40, 8'd100};
    do_scan(8'd102);
    run_pixel("mo_c49", 8'd102, 8'd49, 8'h14, 3'd2, 3'd1, 1'b1, 1'b1);
    run_pixel("mo_c40", 8'd102, 8'd40, 8'h14, 3'd2, 3'd0, 1'b1, 1'b0);
    run_pixel("mo_c55", 8'd102, 8'd55, 8'h14, 3'd2, 3'd7, 1'b1, 1'b1);
    run_pixel("mo_c56", 8'd102, 8'd56, 8'h4A, 3'd6, 3'd0, 1'b0, 1'b0);

    // Overlap priority and column wrap
    clear_mo();
    mo_mem[0] = {8'h33, 8'd250, 8'd50};
    mo_mem[2] = {8'h22, 8'd55,  8'd48};
    mo_mem[5] = {8'h55, 8'd60,  8'd50};
    do_scan(8'd50);
    run_pixel("prio",  8'd50, 8'd60, 8'h22, 3'd2, 3'd5, 1'b1, 1'b0);
    run_pixel("slot5", 8'd50, 8'd72, 8'h55, 3'd0, 3'd4, 1'b1, 1'b1);
    run_pixel("wrap",  8'd50, 8'd2,  8'h33, 3'd0, 3'd0, 1'b1, 1'b1);
    chk("ovf.before", moOverflow, 1'b0);

    // Ten objects on one line: slots 8 and 9 dropped
    clear_mo();
    for (int i = 0; i < 10; i++) mo_mem[i] = {8'(8'h80 + i), 8'(20 * i), 8'd200};
    do_scan(8'd203);
    chk("ovf.set", moOverflow, 1'b1);
    run_pixel("kept7",  8'd203, 8'd145, 8'h87, 3'd3, 3'd5, 1'b1, 1'b0);
    run_pixel("drop8",  8'd203, 8'd163, 8'h27, 3'd3, 3'd3, 1'b0, 1'b0);

    // Scan restarted five cycles in
    mo_mem[12] = {8'h3C, 8'd8, 8'd96};
    @(negedge clk); lineStart = 1'b1; lineNext = 8'd203;
    @(negedge clk); lineStart = 1'b0;
    chk("restart.addr0", moAddr, 4'd0);
    repeat (4) @(negedge clk);
    chk("restart.addr4", moAddr, 4'd4);
    lineStart = 1'b1; lineNext = 8'd100;
    @(negedge clk); lineStart = 1'b0;
    chk("restart.addrback", moAddr, 4'd0);
    run_pixel("scan_empty", 8'd100, 8'd10, 8'h4C, 3'd4, 3'd2, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    run_pixel("restart_mo",    8'd100, 8'd10, 8'h3C, 3'd4, 3'd2, 1'b1, 1'b0);
    run_pixel("restart_stale", 8'd100, 8'd3,  8'h4D, 3'd4, 3'd3, 1'b0, 1'b0);
    chk("ovf.sticky", moOverflow, 1'b1);

    // Reset in the middle of a pixel stream
    @(negedge clk); pixRow = 8'd13; pixCol = 8'd20; pixValid = 1'b1;
    repeat (4) @(negedge clk);
    chk("mrst.vld_before", outValid, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst.vld",   outValid,       1'b0);
    chk("mrst.color", outColor,       2'd0);
    chk("mrst.ismo",  outIsMotion,    1'b0);
    chk("mrst.lkid",  lkSpriteID,     8'h00);
    chk("mrst.lksel", lkMotionSelect, 1'b0);
    chk("mrst.addr",  moAddr,         4'd0);
    chk("mrst.ovf",   moOverflow,     1'b0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("mrst.flushed", outValid, 1'b0);
    @(negedge clk);
    chk("mrst.resume_vld",   outValid, 1'b1);
    chk("mrst.resume_color", outColor, 2'd1);
    pixValid = 1'b0;
    repeat (6) @(negedge clk);
    chk("mrst.idle", outValid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
